lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencing controller between the CPU execute stage and the 32-bit word-addressed data memory.
- Accepts one load or store request at a time, using RISC-V funct3 encodings.
- Issues one or two word accesses with byte enables. Two accesses are needed when a halfword or word straddles a word boundary.
- Merges and sign/zero-extends load data (LB/LH/LW/LBU/LHU) and returns a single-cycle response; the result drives rf.write_data.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request strobe.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access type (RISC-V funct3).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  illegal funct3; valid with rsp_valid.
- mem_req  output  1  memory access request; held until mem_ack.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_W  word-aligned address (low 2 bits = 0).
- mem_be  output  4  byte enables.
- mem_wdata  output  32  byte-lane-positioned write data.
- mem_ack  input  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  input  32  read word.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0 except req_ready=1. Captured registers are cleared.
- States and transitions:
  - IDLE: on accept, latch we/funct3/addr/wdata.
    - If funct3 is illegal, go to RESP with err=1.
    - Otherwise go to ACC0.
  - ACC0: mem_req=1, mem_addr={addr[31:2],2'b00}.
    - On mem_ack: go to ACC1 if the access spans a word boundary, else go to RESP.
  - ACC1: mem_req=1, mem_addr = word address + 4.
    - On mem_ack: go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 in RESP.
- Legal funct3 encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Illegal: loads 011/110/111; stores with funct3 > 010. No memory access is issued.
- Size and span rules: size = 1/2/4 bytes; off = addr[1:0]; the access spans when off + size > 4.
  - Byte accesses never span.
  - LH/LHU/SH span only at off=3.
  - LW/SW span at off 1, 2 or 3.
- Store lanes:
  - mask8 = ((1<<size)-1) << off (8 bits); data64 = wdata << (8*off).
  - ACC0 uses mem_be=mask8[3:0], mem_wdata=data64[31:0].
  - ACC1 uses mem_be=mask8[7:4], mem_wdata=data64[63:32].
- Load merge:
  - mem_rdata is captured on the mem_ack cycle into w0 (ACC0) or w1 (ACC1; w1=0 if no span).
  - raw = ({w1,w0} >> 8*off), truncated to size.
  - Signed loads (LB/LH) sign-extend from bit 7/15; LBU/LHU zero-extend; LW is passed through.
- Loads drive mem_be=4'b1111 (ACC0) or the mask for the bytes needed (ACC1); mem_wdata is don't-care and driven 0.
- Latency: with mem_ack asserted in the first request cycle, an aligned access is accepted at T0, acked at T1, and rsp_valid is high at T2. A spanning access has rsp_valid at T3. mem_ack wait states add cycles one-for-one.
- Ignored inputs:
  - mem_ack while mem_req=0 is ignored.
  - req_valid outside IDLE is ignored and not queued.
- Mid-operation reset: mem_req deasserts immediately (asynchronously); the in-flight access is abandoned with no response.
- mem_addr, mem_be and mem_wdata are stable while mem_req=1 and mem_ack=0.

Test Plan:
- LHU, addr 0x102, mem word 0xFFF41234 → single access with mem_addr=0x100; rsp_rdata=0x0000FFF4, rsp_err=0, rsp_valid at T2 (ack no-wait).
- LH with the same address and word → rsp_rdata=0xFFFFFFF4. LBU addr 0x100 → 0x00000034.
- LHU, addr 0x103, word@0x100=0xAB000000, word@0x104=0x000000CD → two mem_req phases (0x100, then 0x104); rsp_rdata=0x0000CDAB; rsp_valid at T3. Repeat with 2 wait states per ack → T7.
- Stores:
  - SB 0x0000005A at 0x203 → mem_be=1000, mem_wdata=0x5A000000, one access.
  - SW 0xDEADBEEF at 0x202 → phase 1 addr 0x200, be=1100, wdata=0xBEEF0000; phase 2 addr 0x204, be=0011, wdata=0x0000DEAD; rsp_rdata=0.
- Load funct3=011 → no mem_req, rsp_valid with rsp_err=1, rsp_rdata=0 at T1.
- Reset and ignored requests:
  - Assert rst=0 while in ACC0 awaiting ack → mem_req=0 and req_ready=1 immediately; no rsp_valid.
  - req_valid pulsed while busy → ignored, no extra access.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the two buses of the load/store controller:
//   - core side:   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//                  and the single-cycle response rsp_valid/rsp_rdata/rsp_err
//   - memory side: mem_req/mem_we/mem_addr/mem_be/mem_wdata, completed by
//                  mem_ack with mem_rdata valid in the same cycle
// Modports:
//   slave  - the controller's view (takes requests, drives the memory bus)
//   master - the environment's view (core + data memory)
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    // Core request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    // Data memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store sequencer between the execute stage and a 32-bit word-addressed
// data memory. Takes one request at a time (RISC-V funct3 encodings), issues
// one word access, or two when a halfword/word straddles a word boundary,
// then returns a one-cycle response with merged and extended load data.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous, active-low reset
//   bus   - lsu_ctrl_if.slave: core request/response and memory bus
//   busy  - high whenever the controller is not idle
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic                err_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   w0_q;
    logic [DATA_W-1:0]   w1_q;

    // Legal encodings: stores SB/SH/SW; loads LB/LH/LW/LBU/LHU.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 <= 3'b010);
        return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    // ---------------- lane / span arithmetic on the captured request --------
    logic [1:0]          off;
    logic [3:0]          size_mask;
    logic [7:0]          mask8;
    logic [2*DATA_W-1:0] data64;
    logic                spans;
    logic [ADDR_W-1:0]   word_addr;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   load_data;

    assign off = addr_q[1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    // Byte mask and data over an 8-byte window; the upper half belongs to
    // the second word, so any bit set there means the access spans.
    assign mask8     = {4'b0000, size_mask} << off;
    assign data64    = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    assign spans     = |mask8[7:4];
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // w1 stays zero for non-spanning loads, so one shift covers both cases.
    assign raw = DATA_W'({w1_q, w0_q} >> {off, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{raw[7]}},  raw[7:0]};
            3'b001:  load_data = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_data = {24'h0, raw[7:0]};
            3'b101:  load_data = {16'h0, raw[15:0]};
            default: load_data = raw;
        endcase
    end

    // ---------------- state register and request capture -------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        err_q    <= !is_legal(bus.req_we, bus.req_funct3);
                        w0_q     <= '0;
                        w1_q     <= '0;
                    end
                end
                ACC0:    if (bus.mem_ack) w0_q <= bus.mem_rdata;
                ACC1:    if (bus.mem_ack) w1_q <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

    // ---------------- next state and outputs --------------------------------
    logic                req_ready;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [3:0]          mem_be;
    logic [DATA_W-1:0]   mem_wdata;

    // NOTE: every signal gets a default before the case so no path through
    // the block leaves a value held, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = is_legal(bus.req_we, bus.req_funct3) ? ACC0 : RESP;
                end
            end
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr;
                mem_be    = we_q ? mask8[3:0] : 4'b1111;
                mem_wdata = we_q ? data64[DATA_W-1:0] : '0;
                if (bus.mem_ack) state_d = spans ? ACC1 : RESP;
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr + ADDR_W'(4);
                mem_be    = mask8[7:4];
                mem_wdata = we_q ? data64[2*DATA_W-1:DATA_W] : '0;
                if (bus.mem_ack) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : load_data;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_be    = mem_be;
    assign bus.mem_wdata = mem_wdata;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Table-driven bench for lsu_ctrl: each vector holds a request, the memory
// words returned for the first/second access, and hand-computed expectations
// for the memory phases and the response. Hand-written sequences cover wait
// states, requests while busy, stray mem_ack and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic clk;
    logic rst;
    logic busy;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word0;
        logic [31:0] word1;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_n;
        logic [31:0] exp_addr0;
        logic [3:0]  exp_be0;
        logic [31:0] exp_wd0;
        logic [31:0] exp_addr1;
        logic [3:0]  exp_be1;
        logic [31:0] exp_wd1;
    } vec_t;

    // Results of the last transaction
    int          res_lat;
    int          res_n;
    int          res_unstable;
    logic [31:0] res_rdata;
    logic        res_err;
    logic        res_ready0;
    logic        res_after_valid;
    logic        res_after_ready;
    logic        res_after_req;
    logic [31:0] log_addr [2];
    logic [3:0]  log_be   [2];
    logic [31:0] log_wd   [2];
    logic        log_we   [2];

    // Issues one request at a negedge (cycle T0) and plays the memory:
    // each access is acked after 'waits' extra cycles. With hold_valid the
    // core keeps req_valid high (with a different store) while busy.
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input int waits, input bit hold_valid);
        int cyc;
        int wcnt;
        res_lat      = -1;
        res_n        = 0;
        res_unstable = 0;
        res_rdata    = '0;
        res_err      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            log_addr[i] = '0; log_be[i] = '0; log_wd[i] = '0; log_we[i] = 1'b0;
        end
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        res_ready0     = bus.req_ready;
        cyc  = 0;
        wcnt = 0;
        while (cyc < 60 && res_lat < 0) begin
            @(negedge clk);
            cyc++;
            if (hold_valid) begin
                bus.req_we     = 1'b1;
                bus.req_funct3 = 3'b010;
                bus.req_addr   = 32'h0000_0900;
                bus.req_wdata  = 32'hFFFF_FFFF;
            end else begin
                bus.req_valid = 1'b0;
            end
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            if (bus.rsp_valid) begin
                res_lat       = cyc;
                res_rdata     = bus.rsp_rdata;
                res_err       = bus.rsp_err;
                bus.req_valid = 1'b0;
            end else if (bus.mem_req) begin
                if (res_n < 2) begin
                    if (wcnt == 0) begin
                        log_addr[res_n] = bus.mem_addr;
                        log_be[res_n]   = bus.mem_be;
                        log_wd[res_n]   = bus.mem_wdata;
                        log_we[res_n]   = bus.mem_we;
                    end else if (bus.mem_addr !== log_addr[res_n] || bus.mem_be !== log_be[res_n] ||
                                 bus.mem_wdata !== log_wd[res_n]) begin
                        res_unstable++;
                    end
                end
                if (wcnt == waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = (res_n == 0) ? w0 : w1;
                    res_n++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        res_after_valid = bus.rsp_valid;
        res_after_ready = bus.req_ready;
        res_after_req   = bus.mem_req;
    endtask

    vec_t vecs [17];

    initial begin
        logic [2:0] stray;

        //          name       we  f3      addr          wdata         word0         word1         rdata         err  lat n  addr0         be0      wd0           addr1         be1      wd1
        vecs[0]  = '{"lhu_102", 0, 3'b101, 32'h0000_0102, 32'h0,        32'hFFF4_1234, 32'h0,        32'h0000_FFF4, 0, 2, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[1]  = '{"lh_102",  0, 3'b001, 32'h0000_0102, 32'h0,        32'hFFF4_1234, 32'h0,        32'hFFFF_FFF4, 0, 2, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[2]  = '{"lbu_100", 0, 3'b100, 32'h0000_0100, 32'h0,        32'hFFF4_1234, 32'h0,        32'h0000_0034, 0, 2, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[3]  = '{"lhu_103", 0, 3'b101, 32'h0000_0103, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 32'h0000_CDAB, 0, 3, 2, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0104, 4'b0001, 32'h0};
        vecs[4]  = '{"sb_203",  1, 3'b000, 32'h0000_0203, 32'h0000_005A, 32'h1111_1111, 32'h0,        32'h0,         0, 2, 1, 32'h0000_0200, 4'b1000, 32'h5A00_0000, 32'h0,        4'b0000, 32'h0};
        vecs[5]  = '{"sw_202",  1, 3'b010, 32'h0000_0202, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h0,         0, 3, 2, 32'h0000_0200, 4'b1100, 32'hBEEF_0000, 32'h0000_0204, 4'b0011, 32'h0000_DEAD};
        vecs[6]  = '{"ld_011",  0, 3'b011, 32'h0000_0100, 32'h0,        32'h1234_5678, 32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[7]  = '{"lb_101",  0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_8000, 32'h0,        32'hFFFF_FF80, 0, 2, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[8]  = '{"lw_300",  0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 32'h0,        32'h1234_5678, 0, 2, 1, 32'h0000_0300, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{"lw_301",  0, 3'b010, 32'h0000_0301, 32'h0,        32'h4433_2211, 32'h8877_6655, 32'h5544_3322, 0, 3, 2, 32'h0000_0300, 4'b1111, 32'h0,        32'h0000_0304, 4'b0001, 32'h0};
        vecs[10] = '{"sh_401",  1, 3'b001, 32'h0000_0401, 32'h0000_A55A, 32'h0,        32'h0,        32'h0,         0, 2, 1, 32'h0000_0400, 4'b0110, 32'h00A5_5A00, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{"sh_403",  1, 3'b001, 32'h0000_0403, 32'h0000_1234, 32'h0,        32'h0,        32'h0,         0, 3, 2, 32'h0000_0400, 4'b1000, 32'h3400_0000, 32'h0000_0404, 4'b0001, 32'h0000_0012};
        vecs[12] = '{"st_011",  1, 3'b011, 32'h0000_0400, 32'h1234_5678, 32'h0,        32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[13] = '{"ld_110",  0, 3'b110, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 32'h0,        32'h0,         1, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[14] = '{"lb_203",  0, 3'b000, 32'h0000_0203, 32'h0,        32'h7F00_0000, 32'h0,        32'h0000_007F, 0, 2, 1, 32'h0000_0200, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[15] = '{"lw_303",  0, 3'b010, 32'h0000_0303, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44AA, 0, 3, 2, 32'h0000_0300, 4'b1111, 32'h0,        32'h0000_0304, 4'b0111, 32'h0};
        vecs[16] = '{"sw_600",  1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,        32'h0,        32'h0,         0, 2, 1, 32'h0000_0600, 4'b1111, 32'hCAFE_F00D, 32'h0,        4'b0000, 32'h0};

        // ---------------- reset state ----------------
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        #1;
        check("reset.req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("reset.busy",      {31'b0, busy},          32'd0);
        check("reset.mem_req",   {31'b0, bus.mem_req},   32'd0);
        check("reset.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("reset.mem_addr",  bus.mem_addr,           32'h0);
        check("reset.mem_be",    {28'b0, bus.mem_be},    32'h0);
        check("reset.rsp_rdata", bus.rsp_rdata,          32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 17; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].word0, vecs[i].word1, 0, 1'b0);
            check({vecs[i].name, ".ready_t0"}, {31'b0, res_ready0}, 32'd1);
            check({vecs[i].name, ".latency"},  res_lat,              vecs[i].exp_lat);
            check({vecs[i].name, ".rdata"},    res_rdata,            vecs[i].exp_rdata);
            check({vecs[i].name, ".err"},      {31'b0, res_err},     {31'b0, vecs[i].exp_err});
            check({vecs[i].name, ".n_access"}, res_n,                vecs[i].exp_n);
            check({vecs[i].name, ".pulse_end"}, {30'b0, res_after_valid, res_after_ready}, 32'd1);
            if (vecs[i].exp_n >= 1) begin
                check({vecs[i].name, ".addr0"}, log_addr[0],          vecs[i].exp_addr0);
                check({vecs[i].name, ".be0"},   {28'b0, log_be[0]},   {28'b0, vecs[i].exp_be0});
                check({vecs[i].name, ".wd0"},   log_wd[0],            vecs[i].exp_wd0);
                check({vecs[i].name, ".we0"},   {31'b0, log_we[0]},   {31'b0, vecs[i].we});
            end
            if (vecs[i].exp_n == 2) begin
                check({vecs[i].name, ".addr1"}, log_addr[1],          vecs[i].exp_addr1);
                check({vecs[i].name, ".be1"},   {28'b0, log_be[1]},   {28'b0, vecs[i].exp_be1});
                check({vecs[i].name, ".wd1"},   log_wd[1],            vecs[i].exp_wd1);
                check({vecs[i].name, ".we1"},   {31'b0, log_we[1]},   {31'b0, vecs[i].we});
            end
        end

        // ---------------- spanning LHU with 2 wait states per ack ----------
        run_txn(1'b0, 3'b101, 32'h0000_0103, 32'h0, 32'hAB00_0000, 32'h0000_00CD, 2, 1'b0);
        check("wait2.latency",  res_lat,      7);
        check("wait2.rdata",    res_rdata,    32'h0000_CDAB);
        check("wait2.n_access", res_n,        2);
        check("wait2.addr1",    log_addr[1],  32'h0000_0104);
        check("wait2.stable",   res_unstable, 0);

        // ---------------- spanning SW with wait states: lanes held ---------
        run_txn(1'b1, 3'b010, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 32'h0, 3, 1'b0);
        check("sw_wait3.latency", res_lat,            9);
        check("sw_wait3.stable",  res_unstable,       0);
        check("sw_wait3.wd1",     log_wd[1],          32'h0000_DEAD);
        check("sw_wait3.be1",     {28'b0, log_be[1]}, 32'h3);

        // ---------------- req_valid held while busy is ignored ------------
        run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hFFF4_1234, 32'h0, 2, 1'b1);
        check("busyreq.n_access", res_n,               1);
        check("busyreq.addr0",    log_addr[0],         32'h0000_0100);
        check("busyreq.we0",      {31'b0, log_we[0]},  32'd0);
        check("busyreq.rdata",    res_rdata,           32'h0000_FFF4);
        check("busyreq.latency",  res_lat,             4);
        check("busyreq.no_extra", {31'b0, res_after_req}, 32'd0);

        // ---------------- stray mem_ack while idle ----------------
        stray = 3'b000;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stray = stray | {busy, bus.mem_req, bus.rsp_valid};
        end
        bus.mem_ack = 1'b0;
        check("stray_ack.idle", {29'b0, stray}, 32'd0);

        // ---------------- reset while waiting for ack in ACC0 -------------
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0500;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("midrst.pre_req",  {31'b0, bus.mem_req}, 32'd1);
        check("midrst.pre_addr", bus.mem_addr,         32'h0000_0500);
        #2 rst = 1'b0;
        #1;
        check("midrst.mem_req",   {31'b0, bus.mem_req},   32'd0);
        check("midrst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("midrst.busy",      {31'b0, busy},          32'd0);
        @(negedge clk);
        rst   = 1'b1;
        stray = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stray = stray | {busy, bus.mem_req, bus.rsp_valid};
        end
        check("midrst.no_rsp", {29'b0, stray}, 32'd0);

        // Recovery after reset
        run_txn(1'b0, 3'b100, 32'h0000_0100, 32'h0, 32'hFFF4_1234, 32'h0, 0, 1'b0);
        check("recover.rdata",   res_rdata, 32'h0000_0034);
        check("recover.latency", res_lat,   2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
